// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
//    Wraps a free-running LSB-first serial adder so that it behaves as a
//    transaction-level add unit. The block takes two operands through a start
//    handshake and holds them stable on the adder's parallel inputs. It then
//    drives the adder's Sel line for one load cycle followed by WIDTH shift
//    cycles. The serial sum is collected back into a parallel result, which is
//    offered through a valid/ready handshake.
//
// Ports
//    Clk          system clock, rising edge
//    Rst_n        synchronous active-low reset
//    Start        add request, accepted only while Busy=0
//    OpA, OpB     operands, sampled on the accept edge
//    Busy         high whenever the sequencer is not idle
//    AdderDin1/2  registered operands feeding the adder's parallel inputs
//    Sel          adder control: 1 = parallel load, 0 = shift/add
//    SumIn        serial sum bit from the adder, LSB first
//    Result       captured sum, modulo 2^WIDTH
//    ResultValid  Result is complete and stable
//    ResultReady  consumer accepts Result
//
// State table
//    state    | meaning
//    ST_IDLE  | waiting for Start; operands captured on the accept edge
//    ST_LOAD  | one cycle with Sel=1; adder loads operands and clears carry
//    ST_SHIFT | WIDTH cycles; one SumIn bit shifted into Result per edge
//    ST_DONE  | Result valid and held until ResultReady

module serial_add_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             Busy,
   output logic [WIDTH-1:0] AdderDin1,
   output logic [WIDTH-1:0] AdderDin2,
   output logic             Sel,
   input  logic             SumIn,
   output logic [WIDTH-1:0] Result,
   output logic             ResultValid,
   input  logic             ResultReady
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] r_din1;
   logic [WIDTH-1:0] w_din1_nxt;
   logic [WIDTH-1:0] r_din2;
   logic [WIDTH-1:0] w_din2_nxt;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_result_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             r_busy;
   logic             r_sel;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_din1_nxt   = r_din1;
      w_din2_nxt   = r_din2;
      w_result_nxt = r_result;
      w_valid_nxt  = r_valid;
      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_din1_nxt  = OpA;
               w_din2_nxt  = OpB;
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            // LSB-first: each new bit enters at the top and moves down
            w_result_nxt = {SumIn, r_result[WIDTH-1:1]};
            w_cnt_nxt    = r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            // Start is deliberately ignored here, even together with ResultReady
            if (ResultReady) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Busy and Sel are registered from the next state so they line up
   // exactly with the state they describe.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_din1   <= '0;
         r_din2   <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_sel    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_din1   <= w_din1_nxt;
         r_din2   <= w_din2_nxt;
         r_result <= w_result_nxt;
         r_valid  <= w_valid_nxt;
         r_busy   <= (w_state_nxt != ST_IDLE);
         r_sel    <= (w_state_nxt == ST_LOAD);
      end
   end

   assign Busy        = r_busy;
   assign Sel         = r_sel;
   assign AdderDin1   = r_din1;
   assign AdderDin2   = r_din2;
   assign Result      = r_result;
   assign ResultValid = r_valid;

endmodule

// File: tb/tb_serial_add_sequencer.sv
module tb_serial_add_sequencer;

   localparam int W = 4;

   logic         Clk = 1'b0;
   logic         Rst_n = 1'b0;
   logic         Start = 1'b0;
   logic [W-1:0] OpA = '0;
   logic [W-1:0] OpB = '0;
   logic         Busy;
   logic [W-1:0] AdderDin1;
   logic [W-1:0] AdderDin2;
   logic         Sel;
   logic         SumIn;
   logic [W-1:0] Result;
   logic         ResultValid;
   logic         ResultReady = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   serial_add_sequencer #(.WIDTH(W)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .OpA(OpA), .OpB(OpB),
      .Busy(Busy), .AdderDin1(AdderDin1), .AdderDin2(AdderDin2), .Sel(Sel),
      .SumIn(SumIn), .Result(Result), .ResultValid(ResultValid),
      .ResultReady(ResultReady)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Behavioural SerialAdd: parallel load with carry clear on Sel=1,
   // otherwise shift both operands right and propagate the carry.
   logic [W-1:0] m_a = '0;
   logic [W-1:0] m_b = '0;
   logic         m_c = 1'b0;
   always @(posedge Clk) begin
      if (Sel) begin
         m_a <= AdderDin1;
         m_b <= AdderDin2;
         m_c <= 1'b0;
      end else begin
         m_a <= m_a >> 1;
         m_b <= m_b >> 1;
         m_c <= (m_a[0] & m_b[0]) | (m_c & (m_a[0] ^ m_b[0]));
      end
   end
   assign SumIn = m_a[0] ^ m_b[0] ^ m_c;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int ref_sum(input int a, input int b);
      return (a + b) % (1 << W);
   endfunction

   int last_accept = -1;

   // Called at a negedge with the DUT idle; returns at the negedge of the
   // first cycle in which ResultValid should be high.
   task automatic issue(input int a, input int b, input string tag);
      chk({tag, " idle_before"}, int'(Busy), 0);
      Start = 1'b1;
      OpA = W'(a);
      OpB = W'(b);
      last_accept = cyc;
      @(negedge Clk);
      Start = 1'b0;
      chk({tag, " sel_load"}, int'(Sel), 1);
      chk({tag, " busy_load"}, int'(Busy), 1);
      chk({tag, " din1"}, int'(AdderDin1), a);
      chk({tag, " din2"}, int'(AdderDin2), b);
      for (int i = 0; i < W; i++) begin
         @(negedge Clk);
         chk({tag, " sel_shift"}, int'(Sel), 0);
         chk({tag, " valid_early"}, int'(ResultValid), 0);
      end
      @(negedge Clk);
      chk({tag, " valid"}, int'(ResultValid), 1);
      chk({tag, " result"}, int'(Result), ref_sum(a, b));
   endtask

   task automatic consume(input string tag);
      ResultReady = 1'b1;
      @(negedge Clk);
      ResultReady = 1'b0;
      chk({tag, " idle_after"}, int'(Busy), 0);
      chk({tag, " valid_clear"}, int'(ResultValid), 0);
   endtask

   typedef struct {
      int a;
      int b;
      int exp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{a: 12, b: 1, exp: 13};
      vecs[1] = '{a: 15, b: 1, exp: 0};
      vecs[2] = '{a: 11, b: 6, exp: 1};
      vecs[3] = '{a: 0,  b: 0, exp: 0};
      vecs[4] = '{a: 9,  b: 9, exp: 2};

      // Reset held with Start asserted
      Rst_n = 1'b0;
      Start = 1'b1;
      OpA = 4'hF;
      OpB = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         chk("rst busy", int'(Busy), 0);
         chk("rst sel", int'(Sel), 0);
         chk("rst valid", int'(ResultValid), 0);
         chk("rst result", int'(Result), 0);
         chk("rst din1", int'(AdderDin1), 0);
         chk("rst din2", int'(AdderDin2), 0);
      end
      Rst_n = 1'b1;
      Start = 1'b0;
      repeat (2) begin
         @(negedge Clk);
         chk("post_rst idle", int'(Busy), 0);
      end

      // Table-driven vectors with fixed expectations
      for (int i = 0; i < 5; i++) begin
         issue(vecs[i].a, vecs[i].b, "vec");
         chk("vec table_result", int'(Result), vecs[i].exp);
         consume("vec");
         @(negedge Clk);
      end

      // Backpressure: Start pulses and operand changes while in DONE
      issue(12, 1, "bp");
      for (int i = 0; i < 10; i++) begin
         Start = i[0];
         OpA = 4'b0011;
         @(negedge Clk);
         chk("bp result_held", int'(Result), 13);
         chk("bp busy", int'(Busy), 1);
         chk("bp valid", int'(ResultValid), 1);
         chk("bp din1", int'(AdderDin1), 12);
      end
      Start = 1'b1;
      ResultReady = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      ResultReady = 1'b0;
      chk("bp idle_after_ready", int'(Busy), 0);
      chk("bp valid_cleared", int'(ResultValid), 0);
      @(negedge Clk);
      chk("bp start_not_queued", int'(Busy), 0);

      // Reset in the middle of SHIFT after two bits captured
      Start = 1'b1;
      OpA = 4'b1100;
      OpB = 4'b0001;
      @(negedge Clk);
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      Rst_n = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      chk("midrst busy", int'(Busy), 0);
      chk("midrst result", int'(Result), 0);
      chk("midrst valid", int'(ResultValid), 0);
      chk("midrst sel", int'(Sel), 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         chk("midrst no_valid", int'(ResultValid), 0);
      end
      issue(5, 2, "midrst_fresh");
      chk("midrst fresh_result", int'(Result), 7);
      consume("midrst_fresh");

      // Back-to-back with ResultReady tied high
      begin
         int prev;
         int want[3];
         int aa[3];
         int bb[3];
         aa = '{1, 7, 15};
         bb = '{2, 8, 15};
         want = '{3, 15, 14};
         ResultReady = 1'b1;
         prev = -1;
         for (int i = 0; i < 3; i++) begin
            issue(aa[i], bb[i], "b2b");
            chk("b2b result", int'(Result), want[i]);
            if (prev >= 0) chk("b2b spacing", last_accept - prev, 7);
            prev = last_accept;
            @(negedge Clk);
            chk("b2b idle", int'(Busy), 0);
         end
         ResultReady = 1'b0;
      end

      // Randomized transactions against the arithmetic reference
      for (int n = 0; n < 25; n++) begin
         int a;
         int b;
         int d;
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         d = int'($urandom_range(0, 3));
         issue(a, b, "rnd");
         for (int j = 0; j < d; j++) begin
            @(negedge Clk);
            chk("rnd hold_valid", int'(ResultValid), 1);
            chk("rnd hold_result", int'(Result), ref_sum(a, b));
         end
         consume("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

endmodule
